pipe_mux_n: RTL and testbench
=============================

PIPE_MUX_N -- requirements
Module: pipe_mux_n

Interface
REQ-001 Parameter word_size, default 32: data width per input and output, >=1.
REQ-002 Parameter num_inputs, default 4: number of selectable inputs, >=2.
REQ-003 Derived sel_w = max(1, ceil(log2(num_inputs))); not user-overridable.
REQ-004 clk  in  1  single clock; all state updates on rising edge.
REQ-005 reset  in  1  asynchronous, active-high; asserted resets all state immediately.
REQ-006 in_data  in  num_inputs*word_size  input i occupies bits [i*word_size +: word_size].
REQ-007 sel  in  sel_w  input index, sampled with in_valid.
REQ-008 in_valid  in  1  upstream offers a transfer.
REQ-009 in_ready  out  1  block can accept; transfer occurs when in_valid && in_ready at a clock edge.
REQ-010 out_data  out  word_size  selected word at buffer head.
REQ-011 out_valid  out  1  out_data holds a valid word.
REQ-012 out_ready  in  1  downstream accepts; pop occurs when out_valid && out_ready at a clock edge.
REQ-013 sel_err  out  1  sticky out-of-range-select flag; present only with PIPE_MUX_ERR_EN.

Function
REQ-014 On an accepted transfer, the block shall capture in_data word [sel] into a 2-entry FIFO (skid buffer).
REQ-015 Latency: captured word appears on out_data with out_valid=1 exactly one cycle after acceptance, when the buffer was empty.
REQ-016 States: EMPTY (0 words), ONE (1 word), FULL (2 words); state is held in a registered encoding.
REQ-017 Transitions: EMPTY -push-> ONE; ONE -push only-> FULL; ONE -pop only-> EMPTY; ONE -push+pop-> ONE; FULL -pop-> ONE; all other cases hold state.
REQ-018 in_ready = 1 in EMPTY and ONE, 0 in FULL; in_ready is a registered function of state only, with no combinational path from out_ready.
REQ-019 out_valid = 1 in ONE and FULL; out_data is always the oldest word; order is strictly FIFO.
REQ-020 Simultaneous push and pop in ONE: the popped word leaves and the new word becomes head on the next cycle, with no bubble.
REQ-021 out_data shall remain stable while out_valid=1 and out_ready=0.
REQ-022 Select value >= num_inputs on an accepted transfer: the captured word shall be all zeros, and the transfer otherwise proceeds normally.
REQ-023 in_data and sel are ignored when no transfer occurs, including all cycles in FULL.
REQ-024 Throughput: one word per cycle sustained while out_ready=1.

Reset
REQ-025 Reset shall force state EMPTY, in_ready=0 for the reset duration, out_valid=0, out_data=0, and storage=0 (sel_err=0 when present).
REQ-026 Reset asserted mid-operation shall discard all buffered words; in_ready shall be 1 from the first clock edge after deassertion.

Configuration
REQ-027 Macro PIPE_MUX_ERR_EN defined: the sel_err port exists and is set on any accepted transfer with sel >= num_inputs; it stays set until reset.
REQ-028 PIPE_MUX_ERR_EN undefined: no sel_err port and no error flop; the zero-capture rule of REQ-022 still applies.

Structure
REQ-029 Shared package pipe_mux_pkg: state encoding constants (EMPTY/ONE/FULL) and the sel_w derivation function.
REQ-030 Sub-module mux_skid_buf: a 2-entry word_size FIFO with state machine and handshake; pipe_mux_n adds the input select and error logic around it.

Verification
REQ-031 word_size=32, num_inputs=4; in_data words {A0,B1,C2,D3}; sel=2, in_valid=1 for 1 cycle, out_ready=1 -> next cycle out_data=C2, out_valid=1; the cycle after that, out_valid=0.
REQ-032 Three back-to-back pushes with sel=0,1,3 and out_ready=0 -> state FULL after 2 pushes; in_ready=0; the third push is not accepted; out_data=A0 held stable.
REQ-033 From FULL, assert out_ready for 2 cycles -> out_data sequence A0 then B1; in_ready=1 after the first pop; state reaches EMPTY.
REQ-034 Continuous in_valid=1 and out_ready=1 for 8 cycles with sel cycling 0..3 -> 8 words delivered in order with no bubbles and the stated latency.
REQ-035 num_inputs=3, sel=3 accepted -> out_data=0; sel_err=1 and held when PIPE_MUX_ERR_EN is defined; the port is absent when it is undefined.
REQ-036 Reset asserted asynchronously in FULL between edges -> out_valid=0 and out_data=0 immediately; after deassertion, in_ready=1 and no stale words emerge.

Source files
------------

// File: rtl/pipe_mux_pkg.sv
// pipe_mux_pkg
// Shared definitions for pipe_mux_n and its skid buffer:
//   - state_t     : occupancy state of the 2-entry buffer (EMPTY/ONE/FULL);
//                   the encoding equals the number of stored words
//   - sel_w_calc  : width of the select input for a given number of inputs
package pipe_mux_pkg;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_FULL  = 2'd2
    } state_t;

    // At least one select bit, even for two inputs.
    function automatic int sel_w_calc(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/mux_skid_buf.sv
// mux_skid_buf
// Two-entry FIFO (skid buffer) with valid/ready handshakes on both sides.
//
// Handshake: a push happens on a rising edge where in_valid && in_ready;
// a pop happens on a rising edge where out_valid && out_ready. in_ready is
// a flop driven from the next state only, so there is no combinational path
// from out_ready to in_ready.
//
// Ports:
//   clk, reset          clock, asynchronous active-high reset
//   in_data/in_valid    word offered by upstream
//   in_ready            buffer can take a word (low in FULL and during reset)
//   out_data/out_valid  oldest stored word
//   out_ready           downstream takes the head word
//   state               current occupancy state (debug visibility)
module mux_skid_buf
    import pipe_mux_pkg::*;
#(
    parameter int word_size = 32
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [word_size-1:0] in_data,
    input  logic                 in_valid,
    output logic                 in_ready,
    output logic [word_size-1:0] out_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    output state_t               state
);

    state_t               r_state;
    state_t               w_next_state;
    logic [word_size-1:0] r_head;
    logic [word_size-1:0] r_tail;
    logic                 r_in_ready;
    logic                 w_push;
    logic                 w_pop;

    assign w_push = in_valid && r_in_ready;
    assign w_pop  = out_ready && (r_state != ST_EMPTY);

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_EMPTY: if (w_push) w_next_state = ST_ONE;
            ST_ONE: begin
                if (w_push && !w_pop)      w_next_state = ST_FULL;
                else if (w_pop && !w_push) w_next_state = ST_EMPTY;
            end
            ST_FULL:  if (w_pop) w_next_state = ST_ONE;
            default:  w_next_state = ST_EMPTY;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= ST_EMPTY;
            r_in_ready <= 1'b0;
        end else begin
            r_state    <= w_next_state;
            r_in_ready <= (w_next_state != ST_FULL);
        end
    end

    // r_head is always the oldest word; r_tail only holds data in FULL.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_head <= '0;
            r_tail <= '0;
        end else begin
            case (r_state)
                ST_EMPTY: if (w_push) r_head <= in_data;
                ST_ONE: begin
                    // push+pop: the new word replaces the leaving head, no bubble
                    if (w_push && w_pop) r_head <= in_data;
                    else if (w_push)     r_tail <= in_data;
                end
                ST_FULL:  if (w_pop) r_head <= r_tail;
                default:  ;
            endcase
        end
    end

    assign in_ready  = r_in_ready;
    assign out_valid = (r_state != ST_EMPTY);
    assign out_data  = r_head;
    assign state     = r_state;

endmodule

// File: rtl/pipe_mux_n.sv
// pipe_mux_n
// Selects one of num_inputs words on each accepted transfer and queues it in
// a 2-entry skid buffer. A select at or beyond num_inputs captures zero.
//
// Optional feature macro: PIPE_MUX_ERR_EN adds the sticky sel_err output,
// set by any accepted transfer with an out-of-range select, cleared by reset.
//
// Ports:
//   clk, reset          clock, asynchronous active-high reset
//   in_data             packed inputs, input i at [i*word_size +: word_size]
//   sel                 input index, used only on an accepted transfer
//   in_valid/in_ready   upstream handshake
//   out_data/out_valid  head word of the buffer
//   out_ready           downstream handshake
//   dbg_state           buffer occupancy state (0 EMPTY, 1 ONE, 2 FULL)
//   sel_err             sticky out-of-range flag (PIPE_MUX_ERR_EN only)
module pipe_mux_n
    import pipe_mux_pkg::*;
#(
    parameter int word_size  = 32,
    parameter int num_inputs = 4
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic [num_inputs*word_size-1:0] in_data,
    input  logic [sel_w_calc(num_inputs)-1:0] sel,
    input  logic                            in_valid,
    output logic                            in_ready,
    output logic [word_size-1:0]            out_data,
    output logic                            out_valid,
    input  logic                            out_ready,
    output logic [1:0]                      dbg_state
`ifdef PIPE_MUX_ERR_EN
    ,
    output logic                            sel_err
`endif
);

    localparam int sel_w = sel_w_calc(num_inputs);

    logic [word_size-1:0] w_sel_word;
    logic                 w_in_ready;
    state_t               w_state;

    // Unmatched select values fall through to the zero default.
    always_comb begin
        w_sel_word = '0;
        for (int i = 0; i < num_inputs; i++) begin
            if (sel == sel_w'(i)) w_sel_word = in_data[i*word_size +: word_size];
        end
    end

    mux_skid_buf #(
        .word_size (word_size)
    ) u_buf (
        .clk       (clk),
        .reset     (reset),
        .in_data   (w_sel_word),
        .in_valid  (in_valid),
        .in_ready  (w_in_ready),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .state     (w_state)
    );

    assign in_ready  = w_in_ready;
    assign dbg_state = w_state;

`ifdef PIPE_MUX_ERR_EN
    logic r_sel_err;
    logic w_sel_oor;

    assign w_sel_oor = (32'(sel) >= 32'(num_inputs));

    always_ff @(posedge clk or posedge reset) begin
        if (reset)                                  r_sel_err <= 1'b0;
        else if (in_valid && w_in_ready && w_sel_oor) r_sel_err <= 1'b1;
    end

    assign sel_err = r_sel_err;
`endif

endmodule

// File: tb/tb_pipe_mux_n.sv
module tb_pipe_mux_n;

    localparam int W  = 32;
    localparam int N  = 4;
    localparam int SW = 2;
    localparam int N3 = 3;

    localparam logic [W-1:0] A0 = 32'h000000A0;
    localparam logic [W-1:0] B1 = 32'h000000B1;
    localparam logic [W-1:0] C2 = 32'h000000C2;
    localparam logic [W-1:0] D3 = 32'h000000D3;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    // main DUT: 4 inputs
    logic [N*W-1:0] in_data;
    logic [SW-1:0]  sel;
    logic           in_valid;
    logic           in_ready;
    logic [W-1:0]   out_data;
    logic           out_valid;
    logic           out_ready;
    logic [1:0]     dbg_state;

    // second DUT: 3 inputs, for out-of-range selects
    logic [N3*W-1:0] in_data3;
    logic [SW-1:0]   sel3;
    logic            in_valid3;
    logic            in_ready3;
    logic [W-1:0]    out_data3;
    logic            out_valid3;
    logic            out_ready3;
    logic [1:0]      dbg_state3;

`ifdef PIPE_MUX_ERR_EN
    logic sel_err;
    logic sel_err3;
`endif

    pipe_mux_n #(.word_size(W), .num_inputs(N)) dut (
        .clk(clk), .reset(reset), .in_data(in_data), .sel(sel),
        .in_valid(in_valid), .in_ready(in_ready), .out_data(out_data),
        .out_valid(out_valid), .out_ready(out_ready), .dbg_state(dbg_state)
`ifdef PIPE_MUX_ERR_EN
        , .sel_err(sel_err)
`endif
    );

    pipe_mux_n #(.word_size(W), .num_inputs(N3)) dut3 (
        .clk(clk), .reset(reset), .in_data(in_data3), .sel(sel3),
        .in_valid(in_valid3), .in_ready(in_ready3), .out_data(out_data3),
        .out_valid(out_valid3), .out_ready(out_ready3), .dbg_state(dbg_state3)
`ifdef PIPE_MUX_ERR_EN
        , .sel_err(sel_err3)
`endif
    );

    int n_checks = 0;
    int n_errors = 0;

    // Reference model for the main DUT: a queue of at most two words and
    // the acceptance flag that upstream sees during the coming cycle.
    logic [W-1:0] exp_q[$];
    bit           exp_in_ready;

    function automatic logic [W-1:0] ref_word(input logic [N*W-1:0] d, input int s);
        if (s >= N) return '0;
        return d[s*W +: W];
    endfunction

    // Advance one clock with the currently driven inputs and update the model.
    // Inputs are driven and outputs sampled at the falling edge.
    task automatic tick();
        bit           push;
        bit           pop;
        logic [W-1:0] word;
        push = in_valid && exp_in_ready;
        pop  = out_ready && (exp_q.size() > 0);
        word = ref_word(in_data, int'(sel));
        @(posedge clk);
        if (pop)  void'(exp_q.pop_front());
        if (push) exp_q.push_back(word);
        exp_in_ready = (exp_q.size() < 2);
        @(negedge clk);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        in_valid = 1'b0; out_ready = 1'b0; sel = '0; in_data = '0;
        in_valid3 = 1'b0; out_ready3 = 1'b1; sel3 = '0; in_data3 = '0;
        repeat (2) @(negedge clk);
        n_checks++;
        if (in_ready !== 1'b0) begin n_errors++; $display("FAIL reset_in_ready got %b want 0", in_ready); end
        n_checks++;
        if (out_valid !== 1'b0) begin n_errors++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
        n_checks++;
        if (out_data !== '0) begin n_errors++; $display("FAIL reset_out_data got %h want 0", out_data); end
        n_checks++;
        if (dbg_state !== 2'd0) begin n_errors++; $display("FAIL reset_state got %0d want 0", dbg_state); end
`ifdef PIPE_MUX_ERR_EN
        n_checks++;
        if (sel_err3 !== 1'b0) begin n_errors++; $display("FAIL reset_sel_err got %b want 0", sel_err3); end
`endif
        reset = 1'b0;
        exp_q.delete();
        exp_in_ready = 1'b0;
        n_checks++;
        if (in_ready !== 1'b0) begin n_errors++; $display("FAIL in_ready_before_edge got %b want 0", in_ready); end
        tick();
        n_checks++;
        if (in_ready !== 1'b1) begin n_errors++; $display("FAIL in_ready_after_edge got %b want 1", in_ready); end
    endtask

    task automatic test_basic();
        in_data = {D3, C2, B1, A0};
        sel = 2'd2; in_valid = 1'b1; out_ready = 1'b1;
        tick();
        in_valid = 1'b0;
        n_checks++;
        if (out_valid !== 1'b1 || out_data !== C2) begin
            n_errors++; $display("FAIL basic_latency got v=%b d=%h want v=1 d=%h", out_valid, out_data, C2);
        end
        tick();
        n_checks++;
        if (out_valid !== 1'b0) begin n_errors++; $display("FAIL basic_drain got %b want 0", out_valid); end
    endtask

    task automatic test_full_stall();
        in_data = {D3, C2, B1, A0};
        out_ready = 1'b0; in_valid = 1'b1;
        sel = 2'd0; tick();
        sel = 2'd1; tick();
        n_checks++;
        if (dbg_state !== 2'd2 || in_ready !== 1'b0) begin
            n_errors++; $display("FAIL full_state got st=%0d rdy=%b want st=2 rdy=0", dbg_state, in_ready);
        end
        sel = 2'd3; tick();
        sel = 2'd2; tick();
        in_valid = 1'b0;
        n_checks++;
        if (out_data !== A0 || out_valid !== 1'b1 || dbg_state !== 2'd2) begin
            n_errors++; $display("FAIL full_hold got d=%h v=%b st=%0d want d=%h v=1 st=2", out_data, out_valid, dbg_state, A0);
        end
        n_checks++;
        if (exp_q.size() != 2 || exp_q[0] !== A0 || exp_q[1] !== B1) begin
            n_errors++; $display("FAIL full_model got size=%0d want 2 words A0,B1", exp_q.size());
        end
        out_ready = 1'b1;
        tick();
        n_checks++;
        if (out_data !== B1 || out_valid !== 1'b1 || in_ready !== 1'b1) begin
            n_errors++; $display("FAIL first_pop got d=%h v=%b rdy=%b want d=%h v=1 rdy=1", out_data, out_valid, in_ready, B1);
        end
        tick();
        n_checks++;
        if (out_valid !== 1'b0 || dbg_state !== 2'd0) begin
            n_errors++; $display("FAIL second_pop got v=%b st=%0d want v=0 st=0", out_valid, dbg_state);
        end
    endtask

    task automatic test_back_to_back();
        logic [W-1:0] sent[$];
        in_valid = 1'b1; out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            for (int k = 0; k < N; k++) in_data[k*W +: W] = $urandom();
            sel = SW'(i % N);
            sent.push_back(in_data[(i % N)*W +: W]);
            tick();
            n_checks++;
            if (out_valid !== 1'b1 || out_data !== sent[i] || in_ready !== 1'b1) begin
                n_errors++; $display("FAIL b2b_%0d got v=%b d=%h rdy=%b want v=1 d=%h rdy=1", i, out_valid, out_data, in_ready, sent[i]);
            end
        end
        in_valid = 1'b0;
        tick();
        n_checks++;
        if (out_valid !== 1'b0) begin n_errors++; $display("FAIL b2b_drain got %b want 0", out_valid); end
    endtask

    task automatic test_random();
        for (int i = 0; i < 300; i++) begin
            for (int k = 0; k < N; k++) in_data[k*W +: W] = $urandom();
            sel       = SW'($urandom_range(0, N - 1));
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 2) != 0);
            tick();
            n_checks++;
            if (out_valid !== (exp_q.size() > 0) || in_ready !== exp_in_ready || dbg_state !== 2'(exp_q.size())) begin
                n_errors++; $display("FAIL rand_ctrl_%0d got v=%b rdy=%b st=%0d want v=%b rdy=%b st=%0d", i, out_valid, in_ready,
                                     dbg_state, exp_q.size() > 0, exp_in_ready, exp_q.size());
            end
            if (exp_q.size() > 0) begin
                n_checks++;
                if (out_data !== exp_q[0]) begin
                    n_errors++; $display("FAIL rand_data_%0d got %h want %h", i, out_data, exp_q[0]);
                end
            end
        end
        in_valid = 1'b0; out_ready = 1'b1;
        tick(); tick();
    endtask

    task automatic test_oor();
        logic [W-1:0] w1;
        w1 = $urandom();
        in_data3 = {C2, w1, A0};
        sel3 = 2'd3; in_valid3 = 1'b1; out_ready3 = 1'b1;
        tick();
        n_checks++;
        if (out_valid3 !== 1'b1 || out_data3 !== '0) begin
            n_errors++; $display("FAIL oor_zero got v=%b d=%h want v=1 d=0", out_valid3, out_data3);
        end
`ifdef PIPE_MUX_ERR_EN
        n_checks++;
        if (sel_err3 !== 1'b1) begin n_errors++; $display("FAIL oor_err_set got %b want 1", sel_err3); end
`endif
        sel3 = 2'd1;
        tick();
        n_checks++;
        if (out_valid3 !== 1'b1 || out_data3 !== w1) begin
            n_errors++; $display("FAIL oor_next got v=%b d=%h want v=1 d=%h", out_valid3, out_data3, w1);
        end
        in_valid3 = 1'b0;
        tick();
        n_checks++;
        if (out_valid3 !== 1'b0) begin n_errors++; $display("FAIL oor_drain got %b want 0", out_valid3); end
`ifdef PIPE_MUX_ERR_EN
        n_checks++;
        if (sel_err3 !== 1'b1) begin n_errors++; $display("FAIL oor_err_held got %b want 1", sel_err3); end
        n_checks++;
        if (sel_err !== 1'b0) begin n_errors++; $display("FAIL inrange_no_err got %b want 0", sel_err); end
`endif
    endtask

    task automatic test_async_reset();
        logic [W-1:0] w;
        in_data = {D3, C2, B1, A0};
        out_ready = 1'b0; in_valid = 1'b1;
        sel = 2'd3; tick();
        sel = 2'd2; tick();
        in_valid = 1'b0;
        n_checks++;
        if (dbg_state !== 2'd2) begin n_errors++; $display("FAIL pre_reset_full got %0d want 2", dbg_state); end
        #2 reset = 1'b1;
        #1;
        n_checks++;
        if (out_valid !== 1'b0 || out_data !== '0 || in_ready !== 1'b0 || dbg_state !== 2'd0) begin
            n_errors++; $display("FAIL async_reset got v=%b d=%h rdy=%b st=%0d want all 0", out_valid, out_data, in_ready, dbg_state);
        end
        exp_q.delete();
        exp_in_ready = 1'b0;
        @(posedge clk); @(negedge clk);
        reset = 1'b0;
        out_ready = 1'b1;
        tick();
        n_checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            n_errors++; $display("FAIL post_reset got rdy=%b v=%b want rdy=1 v=0", in_ready, out_valid);
        end
        tick();
        n_checks++;
        if (out_valid !== 1'b0) begin n_errors++; $display("FAIL no_stale got %b want 0", out_valid); end
        w = $urandom();
        in_data[1*W +: W] = w;
        sel = 2'd1; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        n_checks++;
        if (out_valid !== 1'b1 || out_data !== w) begin
            n_errors++; $display("FAIL post_reset_push got v=%b d=%h want v=1 d=%h", out_valid, out_data, w);
        end
        tick();
        n_checks++;
        if (out_valid !== 1'b0) begin n_errors++; $display("FAIL post_reset_drain got %b want 0", out_valid); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_full_stall();
        test_back_to_back();
        test_random();
        test_oor();
        test_async_reset();
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
